// File: rtl/tt_nco_pkg.sv
// Shared definitions for the multiphase NCO: FSM state encoding, the
// tuning-word saturation helper and the dither LFSR constants.
package tt_nco_pkg;

  // Run-control states of the oscillator.
  typedef enum logic [1:0] {
    NCO_IDLE  = 2'd0,
    NCO_RUN   = 2'd1,
    NCO_DRAIN = 2'd2
  } nco_state_t;

  // Width used for clamping; wide enough for any tuning-word sum with ACC_W <= 62.
  localparam int SAT_W = 64;

  // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Clamp a signed value into [lo, hi].
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] value,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    logic signed [SAT_W-1:0] result;
    result = value;
    if (value < lo) result = lo;
    else if (value > hi) result = hi;
    saturate = result;
  endfunction

endpackage

// File: rtl/tt_nco_ctrl_if.sv
// Control port of the NCO: converts the signed PI word into a clamped tuning
// word and holds it in a single pending slot until the core applies it.
//
// Handshake: a word is accepted on a cycle where ctrl_valid and ctrl_ready
// are both high; ctrl_ready is simply ~pending, so after an accept the port
// stays busy until the core pulses apply, and ready is high again on the
// following cycle. A valid held while ready is low is not consumed.
module tt_nco_ctrl_if
  import tt_nco_pkg::*;
#(
  parameter int     ACC_W      = 24,
  parameter int     CTRL_SHIFT = 10,
  parameter longint BASE_FTW   = 64'h0001_0000,
  parameter longint FTW_MIN    = 1,
  parameter longint FTW_MAX    = longint'(1) << (ACC_W - 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] control,
  input  logic               ctrl_valid,
  input  logic               apply,
  output logic               ctrl_ready,
  output logic               pending,
  output logic [ACC_W-1:0]   pending_ftw,
  output logic               sat
);

  // Arithmetic width: two guard bits above the wider of accumulator and control.
  localparam int T_W = ((ACC_W > 32) ? ACC_W : 32) + 2;

  logic signed [T_W-1:0]   ctrl_ext;
  logic signed [T_W-1:0]   t_sum;
  logic signed [SAT_W-1:0] t_wide;
  logic signed [SAT_W-1:0] t_clamped;
  logic [ACC_W-1:0]        clamp_ftw;
  logic                    clamped;
  logic                    accept;

  assign ctrl_ready = ~pending;
  assign accept     = ctrl_valid & ctrl_ready;

  // Tuning word = base + scaled control, then clamped into the legal range.
  always_comb begin
    ctrl_ext  = T_W'(control);
    t_sum     = (ctrl_ext >>> CTRL_SHIFT) + T_W'(BASE_FTW);
    t_wide    = SAT_W'(t_sum);
    t_clamped = saturate(t_wide, FTW_MIN, FTW_MAX);
    clamped   = (t_clamped != t_wide);
    clamp_ftw = ACC_W'(t_clamped);
  end

  // Pending slot: filled on accept, emptied when the core applies the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      pending_ftw <= '0;
      sat         <= 1'b0;
    end else if (accept) begin
      pending     <= 1'b1;
      pending_ftw <= clamp_ftw;
      sat         <= clamped;
    end else if (apply) begin
      pending     <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_nco_multiphase.sv
// Multiphase numerically controlled oscillator. A phase accumulator clocked
// by the system clock produces a 50%-duty generated clock (accumulator MSB)
// and NUM_PH equally spaced phase taps. New tuning words from the control
// port take effect only on an accumulator carry, so every output period is
// generated with one consistent word.
//
// Build option: define TT_NCO_DITHER_EN to add a 16-bit LFSR whose low bits
// are added to the accumulator increment while running.
module tt_nco_multiphase
  import tt_nco_pkg::*;
#(
  parameter int     ACC_W      = 24,
  parameter int     CTRL_SHIFT = 10,
  parameter longint BASE_FTW   = 64'h0001_0000,
  parameter longint FTW_MIN    = 1,
  parameter longint FTW_MAX    = longint'(1) << (ACC_W - 1),
  parameter int     NUM_PH     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic signed [31:0] i_control,
  input  logic               i_ctrl_valid,
  output logic               o_ctrl_ready,
  output logic               o_clk_gen,
  output logic [NUM_PH-1:0]  o_phase,
  output logic               o_wrap,
  output logic [ACC_W-1:0]   o_ftw,
  output logic               o_sat,
  output logic [1:0]         o_state
);

  // Word in use after reset: the base word, clamped like any other.
  localparam logic [ACC_W-1:0] FTW_RESET = ACC_W'(saturate(BASE_FTW, FTW_MIN, FTW_MAX));
  // Accumulator offset between adjacent phase taps.
  localparam logic [ACC_W-1:0] PH_STEP =
    ACC_W'((longint'(1) << ACC_W) / longint'(NUM_PH));

  nco_state_t          state;
  nco_state_t          state_next;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    ftw;
  logic [ACC_W-1:0]    inc;
  logic [ACC_W:0]      sum;
  logic                carry;
  logic                carry_r;
  logic                apply;
  logic                running;
  logic                pending;
  logic [ACC_W-1:0]    pending_ftw;
  logic [NUM_PH-1:0]   phase_next;

  tt_nco_ctrl_if #(
    .ACC_W      (ACC_W),
    .CTRL_SHIFT (CTRL_SHIFT),
    .BASE_FTW   (BASE_FTW),
    .FTW_MIN    (FTW_MIN),
    .FTW_MAX    (FTW_MAX)
  ) u_ctrl_if (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .control     (i_control),
    .ctrl_valid  (i_ctrl_valid),
    .apply       (apply),
    .ctrl_ready  (o_ctrl_ready),
    .pending     (pending),
    .pending_ftw (pending_ftw),
    .sat         (o_sat)
  );

  assign running = (state != NCO_IDLE);
  assign o_state = state;
  assign o_ftw   = ftw;

`ifdef TT_NCO_DITHER_EN
  // Number of LFSR bits folded into the increment.
  localparam int DW = (ACC_W - 1 < 4) ? ACC_W - 1 : 4;

  logic [15:0] lfsr;

  // Dither LFSR steps only while the accumulator is running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr <= LFSR_SEED;
    else if (running) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign inc = ftw + ACC_W'(lfsr[DW-1:0]);
`else
  assign inc = ftw;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= NCO_IDLE;
    else state <= state_next;
  end

  // Next state, next accumulator value and the tuning-word apply point.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    carry      = 1'b0;
    apply      = 1'b0;
    sum        = {1'b0, acc} + {1'b0, inc};
    case (state)
      NCO_IDLE: begin
        // Nothing is being generated, so a new word can land immediately.
        apply = pending;
        if (i_enable) state_next = NCO_RUN;
      end
      NCO_RUN: begin
        acc_next = sum[ACC_W-1:0];
        carry    = sum[ACC_W];
        apply    = pending & sum[ACC_W];
        if (!i_enable) state_next = NCO_DRAIN;
      end
      NCO_DRAIN: begin
        // Finish the current period; stop cleanly at the carry.
        acc_next = sum[ACC_W-1:0];
        carry    = sum[ACC_W];
        apply    = pending & sum[ACC_W];
        if (i_enable) begin
          state_next = NCO_RUN;
        end else if (sum[ACC_W]) begin
          state_next = NCO_IDLE;
          acc_next   = '0;
        end
      end
      default: begin
        state_next = NCO_IDLE;
        acc_next   = '0;
      end
    endcase
  end

  // Accumulator and tuning word; the word switches on the carry edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
      ftw <= FTW_RESET;
    end else begin
      acc <= acc_next;
      if (apply) ftw <= pending_ftw;
    end
  end

  // Phase taps: tap k reads the accumulator advanced by k/NUM_PH of a turn.
  for (genvar k = 0; k < NUM_PH; k++) begin : g_tap
    logic [ACC_W-1:0] tap_acc;
    assign tap_acc       = acc + ACC_W'(k) * PH_STEP;
    assign phase_next[k] = running & tap_acc[ACC_W-1];
  end

  // Output registers; carry is staged once more so o_wrap lines up with the
  // falling edge of o_clk_gen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_phase <= '0;
      carry_r <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      o_phase <= phase_next;
      carry_r <= carry;
      o_wrap  <= carry_r;
    end
  end

  assign o_clk_gen = o_phase[0];

endmodule
